// File: rtl/fetch_if_id_stage_if.sv
// Bundle of fetch-stage signals: hazard/branch control, instruction-memory handshake and IF/ID outputs.
// Optional perf counters appear when FETCH_PERF_CNT_EN is defined.
interface fetch_if_id_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Inst;
    logic        IF_ID_valid;
    logic [4:0]  IF_ID_RegisterRs1;
    logic [4:0]  IF_ID_RegisterRs2;
    logic        fetch_busy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    modport master (
        input  stall, branch_taken, branch_target, imem_valid, imem_rdata,
        output imem_req, imem_addr, IF_ID_PC, IF_ID_Inst, IF_ID_valid,
               IF_ID_RegisterRs1, IF_ID_RegisterRs2, fetch_busy,
               perf_stall_cycles, perf_flush_count
    );
    modport slave (
        output stall, branch_taken, branch_target, imem_valid, imem_rdata,
        input  imem_req, imem_addr, IF_ID_PC, IF_ID_Inst, IF_ID_valid,
               IF_ID_RegisterRs1, IF_ID_RegisterRs2, fetch_busy,
               perf_stall_cycles, perf_flush_count
    );
`else
    modport master (
        input  stall, branch_taken, branch_target, imem_valid, imem_rdata,
        output imem_req, imem_addr, IF_ID_PC, IF_ID_Inst, IF_ID_valid,
               IF_ID_RegisterRs1, IF_ID_RegisterRs2, fetch_busy
    );
    modport slave (
        output stall, branch_taken, branch_target, imem_valid, imem_rdata,
        input  imem_req, imem_addr, IF_ID_PC, IF_ID_Inst, IF_ID_valid,
               IF_ID_RegisterRs1, IF_ID_RegisterRs2, fetch_busy
    );
`endif
endinterface

// File: rtl/fetch_if_id_stage.sv
// Fetch stage with single-outstanding imem requests, stall skid buffer, branch flush and IF/ID register.
// Define FETCH_PERF_CNT_EN to add stall-cycle and flush counters.
module fetch_if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input logic                 clk,
    input logic                 rst,
    fetch_if_id_stage_if.master bus
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} fetchState_t;

    fetchState_t state;
    fetchState_t nextState;

    logic        primed;
    logic [31:0] pc;
    logic [31:0] skidPc;
    logic [31:0] skidInst;
    logic [31:0] ifPc;
    logic [31:0] ifInst;
    logic        ifValid;

    logic        flush;
    logic        deliver;
    logic [31:0] deliverPc;
    logic [31:0] deliverInst;

    assign flush = bus.branch_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= nextState;
        end
    end

    // primed keeps the first request off the bus until one edge after reset release
    always_comb begin
        nextState = state;
        case (state)
            S_REQ: begin
                if (primed) begin
                    nextState = flush ? S_DRAIN : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    nextState = bus.imem_valid ? S_REQ : S_DRAIN;
                end else if (bus.imem_valid) begin
                    nextState = bus.stall ? S_HOLD : S_REQ;
                end
            end
            S_HOLD: begin
                if (flush || !bus.stall) begin
                    nextState = S_REQ;
                end
            end
            S_DRAIN: begin
                if (bus.imem_valid) begin
                    nextState = S_REQ;
                end
            end
            default: nextState = S_REQ;
        endcase
    end

    always_comb begin
        bus.imem_req   = (state == S_REQ) && primed;
        bus.imem_addr  = pc;
        bus.fetch_busy = (state == S_WAIT) || (state == S_DRAIN);
    end

    always_comb begin
        deliver     = 1'b0;
        deliverPc   = pc;
        deliverInst = bus.imem_rdata;
        if (!flush && !bus.stall) begin
            if (state == S_WAIT) begin
                deliver = bus.imem_valid;
            end else if (state == S_HOLD) begin
                deliver     = 1'b1;
                deliverPc   = skidPc;
                deliverInst = skidInst;
            end
        end
    end

    // Without a flush, a non-stalled cycle always rewrites IF/ID so decode never sees a repeat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed   <= 1'b0;
            pc       <= RESET_PC;
            skidPc   <= 32'h0;
            skidInst <= 32'h0;
            ifPc     <= 32'h0;
            ifInst   <= NOP_INST;
            ifValid  <= 1'b0;
        end else begin
            primed <= 1'b1;
            if (flush) begin
                pc       <= {bus.branch_target[31:2], 2'b00};
                skidPc   <= 32'h0;
                skidInst <= 32'h0;
                ifPc     <= 32'h0;
                ifInst   <= NOP_INST;
                ifValid  <= 1'b0;
            end else if (bus.stall) begin
                if (state == S_WAIT && bus.imem_valid) begin
                    skidPc   <= pc;
                    skidInst <= bus.imem_rdata;
                end
            end else if (deliver) begin
                pc      <= pc + 32'd4;
                ifPc    <= deliverPc;
                ifInst  <= deliverInst;
                ifValid <= 1'b1;
                if (state == S_HOLD) begin
                    skidPc   <= 32'h0;
                    skidInst <= 32'h0;
                end
            end else begin
                ifPc    <= pc;
                ifInst  <= NOP_INST;
                ifValid <= 1'b0;
            end
        end
    end

    assign bus.IF_ID_PC          = ifPc;
    assign bus.IF_ID_Inst        = ifInst;
    assign bus.IF_ID_valid       = ifValid;
    assign bus.IF_ID_RegisterRs1 = ifInst[19:15];
    assign bus.IF_ID_RegisterRs2 = ifInst[24:20];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stallCycles;
    logic [31:0] flushCount;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCycles <= 32'h0;
            flushCount  <= 32'h0;
        end else begin
            if (bus.stall && !flush) begin
                stallCycles <= stallCycles + 32'd1;
            end
            if (flush) begin
                flushCount <= flushCount + 32'd1;
            end
        end
    end

    assign bus.perf_stall_cycles = stallCycles;
    assign bus.perf_flush_count  = flushCount;
`endif

endmodule

// File: tb/tb_fetch_if_id_stage.sv
// Randomised self-checking bench for fetch_if_id_stage against a flag-based behavioural model.
// Perf counter checks are included when FETCH_PERF_CNT_EN is defined.
module tb_fetch_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    fetch_if_id_stage_if bus();

    fetch_if_id_stage #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [31:0] mPc, mIfPc, mIfInst, mHeldInst, mHeldPc;
    logic [31:0] mStallCnt, mFlushCnt;
    bit          mIfValid, mPrimed, mOutstanding, mDrain, mHeld;

    bit          reqRecorded = 1'b0;
    logic [31:0] reqAddr;
    int          respDelay = 0;
    logic [31:0] respAddr;
    int          memLat = 1;
    logic [31:0] savedPc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        if (a == 32'h4) return 32'h0010_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // A request goes out whenever nothing is in flight and nothing is parked
    function automatic bit expReq();
        return mPrimed && !mOutstanding && !mHeld;
    endfunction

    function automatic bit atResponse();
        return mOutstanding && !mDrain && bus.imem_valid;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq()));
        if (expReq()) checkOutput("imem_addr", bus.imem_addr, mPc);
        checkOutput("IF_ID_PC", bus.IF_ID_PC, mIfPc);
        checkOutput("IF_ID_Inst", bus.IF_ID_Inst, mIfInst);
        checkOutput("IF_ID_valid", 32'(bus.IF_ID_valid), 32'(mIfValid));
        checkOutput("Rs1", 32'(bus.IF_ID_RegisterRs1), 32'(mIfInst[19:15]));
        checkOutput("Rs2", 32'(bus.IF_ID_RegisterRs2), 32'(mIfInst[24:20]));
        checkOutput("fetch_busy", 32'(bus.fetch_busy), 32'(mOutstanding));
`ifdef FETCH_PERF_CNT_EN
        checkOutput("perf_stall", bus.perf_stall_cycles, mStallCnt);
        checkOutput("perf_flush", bus.perf_flush_count, mFlushCnt);
`endif
    endtask

    task automatic modelReset();
        mPc = 32'h0; mIfPc = 32'h0; mIfInst = NOP; mIfValid = 1'b0;
        mPrimed = 1'b0; mOutstanding = 1'b0; mDrain = 1'b0; mHeld = 1'b0;
        mHeldInst = 32'h0; mHeldPc = 32'h0; mStallCnt = 32'h0; mFlushCnt = 32'h0;
    endtask

    task automatic modelStep();
        bit          reqNow;
        bit          dlv;
        logic [31:0] dPc, dInst;
        reqNow = expReq();
        dlv = 1'b0; dPc = 32'h0; dInst = 32'h0;
        reqRecorded = reqNow;
        reqAddr = mPc;
        if (bus.stall && !bus.branch_taken) mStallCnt = mStallCnt + 32'd1;
        if (bus.branch_taken) mFlushCnt = mFlushCnt + 32'd1;
        if (bus.branch_taken) begin
            mPc = {bus.branch_target[31:2], 2'b00};
            mIfPc = 32'h0; mIfInst = NOP; mIfValid = 1'b0;
            mHeld = 1'b0;
            if (reqNow || (mOutstanding && !bus.imem_valid)) begin
                mOutstanding = 1'b1; mDrain = 1'b1;
            end else begin
                mOutstanding = 1'b0; mDrain = 1'b0;
            end
        end else begin
            if (reqNow) begin
                mOutstanding = 1'b1;
            end else if (mOutstanding && bus.imem_valid) begin
                mOutstanding = 1'b0;
                if (mDrain) begin
                    mDrain = 1'b0;
                end else if (bus.stall) begin
                    mHeld = 1'b1; mHeldInst = bus.imem_rdata; mHeldPc = mPc;
                end else begin
                    dlv = 1'b1; dPc = mPc; dInst = bus.imem_rdata;
                end
            end else if (mHeld && !bus.stall) begin
                dlv = 1'b1; dPc = mHeldPc; dInst = mHeldInst; mHeld = 1'b0;
            end
            if (!bus.stall) begin
                if (dlv) begin
                    mIfPc = dPc; mIfInst = dInst; mIfValid = 1'b1; mPc = dPc + 32'd4;
                end else begin
                    mIfPc = mPc; mIfInst = NOP; mIfValid = 1'b0;
                end
            end
        end
        mPrimed = 1'b1;
    endtask

    // Memory answers each request after memLat cycles (random 1..3 when memLat is 0)
    task automatic memTick();
        bus.imem_valid = 1'b0;
        bus.imem_rdata = $urandom;
        if (reqRecorded) begin
            respDelay = (memLat != 0) ? memLat : int'($urandom_range(1, 3));
            respAddr = reqAddr;
            reqRecorded = 1'b0;
        end
        if (respDelay > 0) begin
            respDelay--;
            if (respDelay == 0) begin
                bus.imem_valid = 1'b1;
                bus.imem_rdata = memWord(respAddr);
            end
        end
    endtask

    task automatic applyStimulus(input bit s, input bit b, input logic [31:0] t);
        bus.stall = s;
        bus.branch_taken = b;
        bus.branch_target = t;
        @(negedge clk);
        checkAll();
        modelStep();
        @(posedge clk);
        #1;
        memTick();
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req"}, 32'(bus.imem_req), 32'h0);
        checkOutput({tag, "_busy"}, 32'(bus.fetch_busy), 32'h0);
        checkOutput({tag, "_valid"}, 32'(bus.IF_ID_valid), 32'h0);
        checkOutput({tag, "_inst"}, bus.IF_ID_Inst, NOP);
        checkOutput({tag, "_pc"}, bus.IF_ID_PC, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.stall = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0;
        bus.imem_valid = 1'b0;
        bus.imem_rdata = 32'h0;
        modelReset();
        @(posedge clk);
        #1;
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        memTick();

        // Reset release with 1-cycle memory
        memLat = 1;
        repeat (3) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("firstInst", bus.IF_ID_Inst, 32'h00A0_0093);
        checkOutput("firstPc", bus.IF_ID_PC, 32'h0);
        checkOutput("firstValid", 32'(bus.IF_ID_valid), 32'h1);
        checkOutput("firstRs1", 32'(bus.IF_ID_RegisterRs1), 32'h0);
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("secondInst", bus.IF_ID_Inst, 32'h0010_0113);
        checkOutput("secondRs1", 32'(bus.IF_ID_RegisterRs1), 32'h0);

        // Stall for three cycles as a response arrives
        for (int i = 0; i < 10 && !atResponse(); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("reachStallResp", 32'(atResponse()), 32'h1);
        savedPc = mPc;
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("holdNoReq", 32'(bus.imem_req), 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("skidValid", 32'(bus.IF_ID_valid), 32'h1);
        checkOutput("skidPc", bus.IF_ID_PC, savedPc);
        checkOutput("skidInst", bus.IF_ID_Inst, memWord(savedPc));
        checkOutput("skidAddr", bus.imem_addr, savedPc + 32'd4);

        // Branch in S_WAIT with 3-cycle memory
        memLat = 3;
        for (int i = 0; i < 10 && !(mOutstanding && !mDrain && !bus.imem_valid); i++)
            applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0103);
        checkOutput("flushValid", 32'(bus.IF_ID_valid), 32'h0);
        checkOutput("flushInst", bus.IF_ID_Inst, NOP);
        for (int i = 0; i < 12 && !expReq(); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("redirectAddr", bus.imem_addr, 32'h0000_0100);

        // Flush and stall together
        applyStimulus(1'b1, 1'b1, 32'h0000_0204);
        checkOutput("flushStallValid", 32'(bus.IF_ID_valid), 32'h0);
        checkOutput("flushStallInst", bus.IF_ID_Inst, NOP);
        for (int i = 0; i < 12 && !expReq(); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("flushStallAddr", bus.imem_addr, 32'h0000_0204);

        // Flush coinciding with a response
        memLat = 1;
        for (int i = 0; i < 10 && !atResponse(); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0300);
        checkOutput("dropBusy", 32'(bus.fetch_busy), 32'h0);
        checkOutput("dropReq", 32'(bus.imem_req), 32'h1);
        checkOutput("dropAddr", bus.imem_addr, 32'h0000_0300);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
        for (int i = 0; i < 10 && !(expReq() && mPc == 32'hFFFF_FFFC); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("topAddr", bus.imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 10 && !expReq(); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("wrapAddr", bus.imem_addr, 32'h0);
        checkOutput("wrapIfPc", bus.IF_ID_PC, 32'hFFFF_FFFC);

        // Reset while a request is outstanding; the late response must be ignored
        memLat = 3;
        for (int i = 0; i < 10 && !expReq(); i++) applyStimulus(1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
        checkResetValues("midReset");
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        memTick();
        for (int i = 0; i < 12 && !mIfValid; i++) applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("postResetInst", bus.IF_ID_Inst, 32'h00A0_0093);
        checkOutput("postResetPc", bus.IF_ID_PC, 32'h0);

        // Randomised traffic
        memLat = 0;
        for (int i = 0; i < 500; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
